// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO: start, DATA_BITS LSB-first, optional
// parity, STOP_BITS stop bits, with back-to-back frames while words are queued.
module uart_tx_fifo #(
  parameter int CLOCK_SPEED  = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int CLKS_PER_BIT = CLOCK_SPEED / BAUD_RATE,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [DATA_BITS-1:0]         in_data,
  output logic                         tx,
  output logic                         busy,
  output logic                         tx_done,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CLK_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = 4;
  localparam logic [CLK_W-1:0] CLK_LAST  = CLK_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] word);
    logic p;
    p = ^word;
    if (PARITY == 1) begin
      parity_bit = ~p;
    end else begin
      parity_bit = p;
    end
  endfunction

  logic [DATA_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]     count_r;
  logic                 push_s, pop_s, empty_s, full_s;
  logic [DATA_BITS-1:0] head_s;

  state_t               state_r, state_s;
  logic [CLK_W-1:0]     clk_cnt_r, clk_cnt_s;
  logic [IDX_W-1:0]     bit_idx_r, bit_idx_s;
  logic [DATA_BITS-1:0] shift_r, shift_s;
  logic                 parity_r, parity_s;
  logic                 tx_s, done_s, bit_end_s;

  assign empty_s    = (count_r == '0);
  assign full_s     = (count_r == CNT_FULL);
  assign in_ready   = ~full_s;
  assign push_s     = in_valid & ~full_s;
  assign head_s     = mem_r[rd_ptr_r];
  assign fifo_count = count_r;
  assign bit_end_s  = (clk_cnt_r == CLK_LAST);

  // FIFO storage; words are captured at push so later in_data changes are harmless
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Frame sequencing; tx is computed from the next state so the line is registered
  always_comb begin
    state_s   = state_r;
    clk_cnt_s = clk_cnt_r;
    bit_idx_s = bit_idx_r;
    shift_s   = shift_r;
    parity_s  = parity_r;
    pop_s     = 1'b0;
    done_s    = 1'b0;
    tx_s      = 1'b1;

    if (state_r == ST_IDLE) begin
      clk_cnt_s = '0;
    end else if (bit_end_s) begin
      clk_cnt_s = '0;
    end else begin
      clk_cnt_s = clk_cnt_r + CLK_W'(1);
    end

    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s     = 1'b1;
          shift_s   = head_s;
          parity_s  = parity_bit(head_s);
          bit_idx_s = '0;
          state_s   = ST_START;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          shift_s = {1'b0, shift_r[DATA_BITS-1:1]};
          if (bit_idx_r == DATA_LAST) begin
            bit_idx_s = '0;
            state_s   = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + IDX_W'(1);
          end
        end else begin
          state_s = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
        end else begin
          state_s = ST_PARITY;
        end
      end
      ST_STOP: begin
        if (bit_end_s && (bit_idx_r == STOP_LAST)) begin
          done_s    = 1'b1;
          bit_idx_s = '0;
          // Chain straight into the next frame so there is no idle gap
          if (!empty_s) begin
            pop_s    = 1'b1;
            shift_s  = head_s;
            parity_s = parity_bit(head_s);
            state_s  = ST_START;
          end else begin
            state_s = ST_IDLE;
          end
        end else if (bit_end_s) begin
          bit_idx_s = bit_idx_r + IDX_W'(1);
        end else begin
          state_s = ST_STOP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase

    case (state_s)
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_s[0];
      ST_PARITY: tx_s = parity_s;
      default:   tx_s = 1'b1;
    endcase
  end

  // Transmitter state and registered line outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      clk_cnt_r <= '0;
      bit_idx_r <= '0;
      shift_r   <= '0;
      parity_r  <= 1'b0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state_r   <= state_s;
      clk_cnt_r <= clk_cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      parity_r  <= parity_s;
      tx        <= tx_s;
      busy      <= (state_s != ST_IDLE);
      tx_done   <= done_s;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: five frame formats at 4 clocks per bit, FIFO
// fill/order, and reset in the middle of a frame.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] valid_v, ready_v, tx_v, busy_v, done_v;
  logic [7:0] data_v [4];
  logic [8:0] data9;
  logic [2:0] cnt_v [5];

  // 0: 8N1, 1: 8E1, 2: 8O1, 3: 8N2, 4: 9N1 -- all 4 clocks per bit
  uart_tx_fifo #(.CLOCK_SPEED(4), .BAUD_RATE(1)) u_8n1 (
    .clk(clk), .rst(rst), .in_valid(valid_v[0]), .in_ready(ready_v[0]), .in_data(data_v[0]),
    .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]), .fifo_count(cnt_v[0]));
  uart_tx_fifo #(.CLOCK_SPEED(4), .BAUD_RATE(1), .PARITY(2)) u_8e1 (
    .clk(clk), .rst(rst), .in_valid(valid_v[1]), .in_ready(ready_v[1]), .in_data(data_v[1]),
    .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]), .fifo_count(cnt_v[1]));
  uart_tx_fifo #(.CLOCK_SPEED(4), .BAUD_RATE(1), .PARITY(1)) u_8o1 (
    .clk(clk), .rst(rst), .in_valid(valid_v[2]), .in_ready(ready_v[2]), .in_data(data_v[2]),
    .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]), .fifo_count(cnt_v[2]));
  uart_tx_fifo #(.CLOCK_SPEED(4), .BAUD_RATE(1), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .in_valid(valid_v[3]), .in_ready(ready_v[3]), .in_data(data_v[3]),
    .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]), .fifo_count(cnt_v[3]));
  uart_tx_fifo #(.CLOCK_SPEED(4), .BAUD_RATE(1), .DATA_BITS(9)) u_9n1 (
    .clk(clk), .rst(rst), .in_valid(valid_v[4]), .in_ready(ready_v[4]), .in_data(data9),
    .tx(tx_v[4]), .busy(busy_v[4]), .tx_done(done_v[4]), .fifo_count(cnt_v[4]));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Receiver for dut 0: find the first low cycle, then sample mid-bit every 4 clocks
  task automatic rx_word(output logic [7:0] w);
    int n;
    n = 0;
    w = 8'h00;
    while (tx_v[0] !== 1'b0 && n < 3000) begin
      tick();
      n++;
    end
    chk("rx_start_found", {31'd0, n < 3000}, 32'd1);
    repeat (2) tick();
    for (int i = 0; i < 8; i++) begin
      repeat (4) tick();
      w[i] = tx_v[0];
    end
    repeat (4) tick();
    chk("rx_stop_high", {31'd0, tx_v[0]}, 32'd1);
  endtask

  typedef struct {
    int          dut;
    int          nslots;
    logic [31:0] bits;     // expected line level per bit slot, slot 0 = start bit
    int          done_a;
    int          done_b;   // second tx_done pulse, -1 if none
  } frame_vec_t;

  frame_vec_t vecs [5];
  logic tx_log   [5][96];
  logic busy_log [5][96];
  logic done_log [5][96];
  logic [7:0] exp_words [5];
  logic [7:0] rx_got;
  int idx, lows, dones;
  logic acc;

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{0, 10, 32'b1101001010, 40, -1};                  // 0xA5 8N1
    vecs[1] = '{1, 11, 32'b11000001110, 44, -1};                 // 0x07 even -> parity 1
    vecs[2] = '{2, 11, 32'b10000001110, 44, -1};                 // 0x07 odd  -> parity 0
    vecs[3] = '{3, 22, 32'b1100000000011010101010, 44, 88};      // 0x55,0x00 8N2
    vecs[4] = '{4, 11, 32'b11111111110, 44, -1};                 // 9'h1FF 9N1
    exp_words[0] = 8'h3C; exp_words[1] = 8'h11; exp_words[2] = 8'h22;
    exp_words[3] = 8'h33; exp_words[4] = 8'h44;

    rst = 1'b1;
    valid_v = 5'b00000;
    for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
    data9 = 9'h000;
    repeat (3) tick();
    chk("reset_tx", {27'd0, tx_v}, 32'h1F);
    chk("reset_busy", {27'd0, busy_v}, 32'h0);
    chk("reset_done", {27'd0, done_v}, 32'h0);
    chk("reset_ready", {27'd0, ready_v}, 32'h1F);
    chk("reset_count", {29'd0, cnt_v[0]}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();

    // Frame formats: one push per dut, a second back-to-back word on the 8N2 dut
    valid_v = 5'b11111;
    data_v[0] = 8'hA5; data_v[1] = 8'h07; data_v[2] = 8'h07; data_v[3] = 8'h55;
    data9 = 9'h1FF;
    tick();
    chk("push_count", {29'd0, cnt_v[0]}, 32'd1);
    chk("push_tx_still_idle", {31'd0, tx_v[0]}, 32'd1);
    valid_v = 5'b01000;
    data_v[3] = 8'h00;
    for (int k = 0; k < 96; k++) begin
      tick();
      for (int d = 0; d < 5; d++) begin
        tx_log[d][k]   = tx_v[d];
        busy_log[d][k] = busy_v[d];
        done_log[d][k] = done_v[d];
      end
      if (k == 0) begin
        valid_v = 5'b00000;
        chk("pop_count", {29'd0, cnt_v[0]}, 32'd0);
        chk("queued_count_8n2", {29'd0, cnt_v[3]}, 32'd1);
      end
    end
    for (int v = 0; v < 5; v++) begin
      for (int s = 0; s < vecs[v].nslots; s++) begin
        for (int j = 0; j < 4; j++) begin
          chk($sformatf("tx_d%0d_c%0d", vecs[v].dut, s * 4 + j),
              {31'd0, tx_log[vecs[v].dut][s * 4 + j]}, {31'd0, vecs[v].bits[s]});
        end
      end
      chk($sformatf("idle_after_d%0d", vecs[v].dut),
          {31'd0, tx_log[vecs[v].dut][vecs[v].nslots * 4]}, 32'd1);
      chk($sformatf("busy_first_d%0d", vecs[v].dut), {31'd0, busy_log[vecs[v].dut][0]}, 32'd1);
      chk($sformatf("busy_last_d%0d", vecs[v].dut),
          {31'd0, busy_log[vecs[v].dut][vecs[v].nslots * 4 - 1]}, 32'd1);
      chk($sformatf("busy_end_d%0d", vecs[v].dut),
          {31'd0, busy_log[vecs[v].dut][vecs[v].nslots * 4]}, 32'd0);
      chk($sformatf("done_at_d%0d", vecs[v].dut), {31'd0, done_log[vecs[v].dut][vecs[v].done_a]}, 32'd1);
      dones = 0;
      for (int k = 0; k < 96; k++) dones += int'(done_log[vecs[v].dut][k]);
      chk($sformatf("done_pulses_d%0d", vecs[v].dut), dones, (vecs[v].done_b >= 0) ? 32'd2 : 32'd1);
      if (vecs[v].done_b >= 0) begin
        chk($sformatf("done_b_d%0d", vecs[v].dut), {31'd0, done_log[vecs[v].dut][vecs[v].done_b]}, 32'd1);
      end
    end
    repeat (4) tick();

    // FIFO fill while the line is busy; the fifth held word must never be accepted
    @(negedge clk);
    valid_v = 5'b00001;
    data_v[0] = 8'h3C;
    tick();
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          rx_word(rx_got);
          chk($sformatf("order_%0d", i), {24'd0, rx_got}, {24'd0, exp_words[i]});
        end
      end
      begin
        idx = 0;
        data_v[0] = 8'h11;
        for (int it = 0; it < 12; it++) begin
          acc = ready_v[0];
          tick();
          if (acc) idx++;
          case (idx)
            1: data_v[0] = 8'h22;
            2: data_v[0] = 8'h33;
            3: data_v[0] = 8'h44;
            default: data_v[0] = 8'h55;
          endcase
        end
        chk("accepted_words", idx, 32'd4);
        chk("full_ready", {31'd0, ready_v[0]}, 32'd0);
        chk("full_count", {29'd0, cnt_v[0]}, 32'd4);
        valid_v = 5'b00000;
        data_v[0] = 8'hFF;
        lows = 0;
        while (cnt_v[0] == 3'd4 && lows < 200) begin
          tick();
          lows++;
        end
        chk("count_after_pop", {29'd0, cnt_v[0]}, 32'd3);
        chk("ready_after_pop", {31'd0, ready_v[0]}, 32'd1);
      end
    join
    lows = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if (tx_v[0] == 1'b0) lows++;
    end
    chk("no_extra_frame", lows, 32'd0);

    // Reset in the middle of the data bits with a second word queued
    @(negedge clk);
    valid_v = 5'b00001;
    data_v[0] = 8'hA5;
    tick();
    data_v[0] = 8'h5A;
    tick();
    valid_v = 5'b00000;
    repeat (9) tick();
    chk("pre_reset_low", {31'd0, tx_v[0]}, 32'd0);
    chk("pre_reset_count", {29'd0, cnt_v[0]}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_tx_high", {31'd0, tx_v[0]}, 32'd1);
    chk("async_count", {29'd0, cnt_v[0]}, 32'd0);
    chk("async_busy", {31'd0, busy_v[0]}, 32'd0);
    chk("async_ready", {31'd0, ready_v[0]}, 32'd1);
    dones = 0;
    repeat (2) begin
      tick();
      dones += int'(done_v[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    lows = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (tx_v[0] == 1'b0) lows++;
      dones += int'(done_v[0]);
    end
    chk("reset_discards_queue", lows, 32'd0);
    chk("reset_no_done", dones, 32'd0);
    @(negedge clk);
    valid_v = 5'b00001;
    data_v[0] = 8'h96;
    tick();
    valid_v = 5'b00000;
    rx_word(rx_got);
    chk("post_reset_word", {24'd0, rx_got}, 32'h96);
    repeat (2) tick();
    chk("post_reset_done", {31'd0, done_v[0]}, 32'd1);
    tick();
    chk("post_reset_idle", {31'd0, busy_v[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
